// File: rtl/vga_pkg.sv
// Shared VGA/game constants and types.
// Holds the default card-grid geometry and the chosen-person FSM state type.
package vga_pkg;

  localparam int PG_ROWS   = 3;
  localparam int PG_COLS   = 3;
  localparam int PG_X0     = 64;
  localparam int PG_Y0     = 48;
  localparam int PG_CELL_W = 160;
  localparam int PG_CELL_H = 144;
  localparam int PG_GAP_X  = 32;
  localparam int PG_GAP_Y  = 32;

  typedef enum logic [0:0] {
    CHOOSE,
    PLAY
  } pg_state_t;

endpackage

// File: rtl/person_grid_hit.sv
// Combinational hit test of a pixel position against the ROWS x COLS card grid.
// Returns card ID row*COLS+col+1, or 0 when the point lies in a gap or off the grid.
module person_grid_hit
  import vga_pkg::*;
#(
  parameter int ROWS   = PG_ROWS,
  parameter int COLS   = PG_COLS,
  parameter int ID_W   = 4,
  parameter int X0     = PG_X0,
  parameter int Y0     = PG_Y0,
  parameter int CELL_W = PG_CELL_W,
  parameter int CELL_H = PG_CELL_H,
  parameter int GAP_X  = PG_GAP_X,
  parameter int GAP_Y  = PG_GAP_Y
) (
  input  logic [11:0]     xpos,
  input  logic [11:0]     ypos,
  output logic [ID_W-1:0] id
);

  logic [12:0]     x13;
  logic [12:0]     y13;
  logic            col_ok;
  logic            row_ok;
  logic [ID_W-1:0] col_idx;
  logic [ID_W-1:0] row_idx;

  assign x13 = {1'b0, xpos};
  assign y13 = {1'b0, ypos};

  // Scan from the far end so the lowest index wins if two cells ever share an edge pixel.
  always_comb begin
    col_ok  = 1'b0;
    col_idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (x13 >= 13'(X0 + c * (CELL_W + GAP_X)) &&
          x13 <= 13'(X0 + c * (CELL_W + GAP_X) + CELL_W)) begin
        col_ok  = 1'b1;
        col_idx = ID_W'(c);
      end
    end
  end

  always_comb begin
    row_ok  = 1'b0;
    row_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (y13 >= 13'(Y0 + r * (CELL_H + GAP_Y)) &&
          y13 <= 13'(Y0 + r * (CELL_H + GAP_Y) + CELL_H)) begin
        row_ok  = 1'b1;
        row_idx = ID_W'(r);
      end
    end
  end

  assign id = (col_ok && row_ok) ? ID_W'(row_idx * ID_W'(COLS) + col_idx + ID_W'(1)) : '0;

endmodule

// File: rtl/person_grid_select.sv
// Guess-Who card selector: registers the hovered card and click edges, then runs the
// choose/confirm/eliminate game FSM one cycle later.
module person_grid_select
  import vga_pkg::*;
#(
  parameter int ROWS   = PG_ROWS,
  parameter int COLS   = PG_COLS,
  parameter int ID_W   = 4,
  parameter int X0     = PG_X0,
  parameter int Y0     = PG_Y0,
  parameter int CELL_W = PG_CELL_W,
  parameter int CELL_H = PG_CELL_H,
  parameter int GAP_X  = PG_GAP_X,
  parameter int GAP_Y  = PG_GAP_Y
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [11:0]          xpos,
  input  logic [11:0]          ypos,
  input  logic                 mouse_right,
  input  logic                 mouse_left,
  input  logic                 new_game,
  output logic [ID_W-1:0]      hover_id,
  output logic [ID_W-1:0]      your_person,
  output logic                 locked,
  output logic [ROWS*COLS-1:0] elim_mask,
  output logic [ID_W-1:0]      remaining,
  output logic                 sel_event
);

  localparam int N = ROWS * COLS;

  logic [ID_W-1:0] hit_id;
  logic            rclk_q;
  logic            lclk_q;
  logic            r_prev;
  logic            l_prev;

  pg_state_t       state;
  pg_state_t       nxt_state;
  logic [ID_W-1:0] nxt_person;
  logic            nxt_locked;
  logic [N-1:0]    nxt_mask;
  logic [ID_W-1:0] nxt_remaining;
  logic            nxt_sel;
  logic [N-1:0]    hover_bit;

  person_grid_hit #(
    .ROWS(ROWS), .COLS(COLS), .ID_W(ID_W), .X0(X0), .Y0(Y0),
    .CELL_W(CELL_W), .CELL_H(CELL_H), .GAP_X(GAP_X), .GAP_Y(GAP_Y)
  ) u_hit (
    .xpos(xpos),
    .ypos(ypos),
    .id  (hit_id)
  );

  // Button history survives new_game so a button held across a restart still yields one click.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hover_id <= '0;
      rclk_q   <= 1'b0;
      lclk_q   <= 1'b0;
      r_prev   <= 1'b0;
      l_prev   <= 1'b0;
    end else begin
      hover_id <= hit_id;
      rclk_q   <= mouse_right & ~r_prev;
      lclk_q   <= mouse_left & ~l_prev;
      r_prev   <= mouse_right;
      l_prev   <= mouse_left;
    end
  end

  assign hover_bit = (hover_id != '0) ? (N'(1) << (hover_id - ID_W'(1))) : '0;

  always_comb begin
    nxt_state     = state;
    nxt_person    = your_person;
    nxt_locked    = locked;
    nxt_mask      = elim_mask;
    nxt_remaining = remaining;
    nxt_sel       = 1'b0;
    if (new_game) begin
      nxt_state     = CHOOSE;
      nxt_person    = '0;
      nxt_locked    = 1'b0;
      nxt_mask      = '0;
      nxt_remaining = ID_W'(N);
    end else begin
      case (state)
        CHOOSE: begin
          if (lclk_q) begin
            if (hover_id != '0 && hover_id == your_person) begin
              nxt_state  = PLAY;
              nxt_locked = 1'b1;
            end
          end else if (rclk_q && hover_id != '0) begin
            nxt_person = hover_id;
            nxt_sel    = (hover_id != your_person);
          end
        end
        PLAY: begin
          if (lclk_q && hover_id != '0 && hover_id != your_person) begin
            nxt_mask = elim_mask ^ hover_bit;
            nxt_sel  = 1'b1;
            if ((elim_mask & hover_bit) != '0) begin
              nxt_remaining = remaining + ID_W'(1);
            end else begin
              nxt_remaining = remaining - ID_W'(1);
            end
          end
        end
        default: nxt_state = CHOOSE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CHOOSE;
      your_person <= '0;
      locked      <= 1'b0;
      elim_mask   <= '0;
      remaining   <= ID_W'(N);
      sel_event   <= 1'b0;
    end else begin
      state       <= nxt_state;
      your_person <= nxt_person;
      locked      <= nxt_locked;
      elim_mask   <= nxt_mask;
      remaining   <= nxt_remaining;
      sel_event   <= nxt_sel;
    end
  end

endmodule
